// File: rtl/dec_entry_pkg.sv
// dec_entry_pkg: shared constants, state encoding and helpers for the
// decimal digit-entry block (dec_entry) and its BCD-to-binary converter.
package dec_entry_pkg;

  localparam int DEC_MAX_DIGITS = 3;
  localparam int DEC_WIDTH      = 10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Decimal weights of d2, d1 and d0.
  localparam int W_HUNDREDS = 100;
  localparam int W_TENS     = 10;
  localparam int W_ONES     = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // True when the nibble is a legal BCD digit (0..9).
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/dec_entry_bcd3_to_bin.sv
// bcd3_to_bin: combinational conversion of three BCD digits into binary,
// d2*100 + d1*10 + d0, built only from shifts and adds.
// Ports:
//   i_d2, i_d1, i_d0 : BCD digits, hundreds / tens / ones
//   o_bin            : binary value, 0..999
module bcd3_to_bin
  import dec_entry_pkg::*;
(
  input  logic [3:0]           i_d2,
  input  logic [3:0]           i_d1,
  input  logic [3:0]           i_d0,
  output logic [DEC_WIDTH-1:0] o_bin
);

  logic [DEC_WIDTH-1:0] w_d2;
  logic [DEC_WIDTH-1:0] w_d1;
  logic [DEC_WIDTH-1:0] w_d0;

  assign w_d2 = {6'd0, i_d2};
  assign w_d1 = {6'd0, i_d1};
  assign w_d0 = {6'd0, i_d0};

  // x100 = x64 + x32 + x4 ; x10 = x8 + x2. Max 900+90+9 fits in 10 bits.
  assign o_bin = (w_d2 << 3'd6) + (w_d2 << 3'd5) + (w_d2 << 3'd2)
               + (w_d1 << 3'd3) + (w_d1 << 3'd1)
               + w_d0;

endmodule

// File: rtl/dec_entry.sv
// dec_entry: accepts BCD digits most-significant first, shows the entry in
// progress, and commits it as an unsigned binary value.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   digit_in           : BCD digit, sampled with digit_valid
//   digit_valid        : strobe, append digit
//   backspace          : strobe, drop last digit
//   enter              : strobe, commit entry
//   clear              : strobe, discard entry and clear err
//   entry_value        : binary value of current digits (one cycle behind)
//   digit_count        : digits held, 0..MAX_DIGITS
//   value_out          : last committed value
//   value_valid        : one-cycle pulse when value_out updates
//   err                : sticky error flag
module dec_entry
  import dec_entry_pkg::*;
#(
  parameter int MAX_DIGITS = DEC_MAX_DIGITS,
  parameter int WIDTH      = DEC_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  input  logic             backspace,
  input  logic             enter,
  input  logic             clear,
  output logic [WIDTH-1:0] entry_value,
  output logic [1:0]       digit_count,
  output logic [WIDTH-1:0] value_out,
  output logic             value_valid,
  output logic             err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_d2, r_d1, r_d0;
  logic [3:0]         w_d2_nxt, w_d1_nxt, w_d0_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic               r_err, w_err_nxt;
  logic               w_commit;
  logic [WIDTH-1:0]   w_bin;
  logic [WIDTH-1:0]   r_entry_value;
  logic [WIDTH-1:0]   r_value_out;
  logic               r_value_valid;

  bcd3_to_bin u_bcd3_to_bin (
    .i_d2  (r_d2),
    .i_d1  (r_d1),
    .i_d0  (r_d0),
    .o_bin (w_bin)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next digit/count/err; strobe priority clear > enter > backspace > digit.
  always_comb begin
    w_state_nxt = r_state;
    w_d2_nxt    = r_d2;
    w_d1_nxt    = r_d1;
    w_d0_nxt    = r_d0;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_commit    = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_d2_nxt    = 4'd0;
      w_d1_nxt    = 4'd0;
      w_d0_nxt    = 4'd0;
      w_cnt_nxt   = 2'd0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_COMMIT: begin
          // Digits are still intact here, so w_bin is the value to commit.
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_d2_nxt    = 4'd0;
          w_d1_nxt    = 4'd0;
          w_d0_nxt    = 4'd0;
          w_cnt_nxt   = 2'd0;
          // Enter/backspace are ignored here but still outrank a bad digit.
          if (!enter && !backspace && digit_valid && !is_bcd(digit_in)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end
        ST_IDLE, ST_ENTRY, ST_FULL: begin
          if (enter) begin
            if (r_state != ST_IDLE) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              w_state_nxt = r_state;
            end
          end else if (backspace) begin
            if (r_state != ST_IDLE) begin
              w_d0_nxt    = r_d1;
              w_d1_nxt    = r_d2;
              w_d2_nxt    = 4'd0;
              w_cnt_nxt   = r_cnt - 2'd1;
              w_state_nxt = (r_cnt == 2'd1) ? ST_IDLE : ST_ENTRY;
            end else begin
              w_cnt_nxt = r_cnt;
            end
          end else if (digit_valid) begin
            if (!is_bcd(digit_in) || (r_state == ST_FULL)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_d2_nxt    = r_d1;
              w_d1_nxt    = r_d0;
              w_d0_nxt    = digit_in;
              w_cnt_nxt   = r_cnt + 2'd1;
              w_state_nxt = ((r_cnt + 2'd1) == MAX_CNT) ? ST_FULL : ST_ENTRY;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Digit shift register, count, error flag and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_d2          <= 4'd0;
      r_d1          <= 4'd0;
      r_d0          <= 4'd0;
      r_cnt         <= 2'd0;
      r_err         <= 1'b0;
      r_entry_value <= {WIDTH{1'b0}};
      r_value_out   <= {WIDTH{1'b0}};
      r_value_valid <= 1'b0;
    end else begin
      r_d2          <= w_d2_nxt;
      r_d1          <= w_d1_nxt;
      r_d0          <= w_d0_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err         <= w_err_nxt;
      r_entry_value <= w_bin;
      r_value_valid <= w_commit;
      if (w_commit) begin
        r_value_out <= w_bin;
      end else begin
        r_value_out <= r_value_out;
      end
    end
  end

  assign entry_value = r_entry_value;
  assign digit_count = r_cnt;
  assign value_out   = r_value_out;
  assign value_valid = r_value_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_dec_entry.sv
// tb_dec_entry: directed scenarios plus randomized strobes, checked every
// cycle against a queue-of-digits reference model of dec_entry.
module tb_dec_entry;

  logic       clk;
  logic       resetn;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       backspace;
  logic       enter;
  logic       clear;
  logic [9:0] entry_value;
  logic [1:0] digit_count;
  logic [9:0] value_out;
  logic       value_valid;
  logic       err;

  int n_checks;
  int n_fails;

  // Reference model: digits held, most significant first.
  int q[$];
  int m_ev;
  int m_vo;
  int m_vv;
  int m_err;
  bit m_pend;

  dec_entry dut (
    .clk         (clk),
    .resetn      (resetn),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .backspace   (backspace),
    .enter       (enter),
    .clear       (clear),
    .entry_value (entry_value),
    .digit_count (digit_count),
    .value_out   (value_out),
    .value_valid (value_valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qval();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ev = 0; m_vo = 0; m_vv = 0; m_err = 0; m_pend = 1'b0;
  endtask

  task automatic check_all();
    chk("entry_value", entry_value, m_ev);
    chk("digit_count", digit_count, q.size());
    chk("value_out",   value_out,   m_vo);
    chk("value_valid", value_valid, m_vv);
    chk("err",         err,         m_err);
  endtask

  // One clock cycle with the given strobes, then model update and compare.
  task automatic step(input bit dv, input int d, input bit bs, input bit en, input bit cl);
    digit_valid = dv; digit_in = d[3:0]; backspace = bs; enter = en; clear = cl;
    @(posedge clk);
    m_ev = qval();
    m_vv = 0;
    if (cl) begin
      q.delete(); m_err = 0; m_pend = 1'b0;
    end else if (m_pend) begin
      m_vo = qval(); m_vv = 1; q.delete(); m_pend = 1'b0;
      if (!en && !bs && dv && d > 9) m_err = 1;
    end else if (en) begin
      if (q.size() > 0) m_pend = 1'b1;
    end else if (bs) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (dv) begin
      if (d > 9 || q.size() == 3) m_err = 1;
      else q.push_back(d);
    end
    #1;
    digit_valid = 1'b0; backspace = 1'b0; enter = 1'b0; clear = 1'b0;
    check_all();
  endtask

  task automatic dig(input int d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    model_reset();
    resetn = 1'b0; digit_in = 4'd0; digit_valid = 1'b0;
    backspace = 1'b0; enter = 1'b0; clear = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    resetn = 1'b1;

    // 4,2,7 then enter: 427 committed with a single pulse.
    dig(4); dig(2); dig(7);
    chk("ev_42", entry_value, 42);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("ev_427", entry_value, 427);
    idle();
    chk("vo_427", value_out, 427);
    chk("vv_427", value_valid, 1);
    idle();
    chk("vv_427_low", value_valid, 0);

    // Overflow by a fourth digit, then commit 999 with err sticky.
    dig(9); dig(9); dig(9); dig(5);
    chk("err_full", err, 1);
    chk("cnt_full", digit_count, 3);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("vo_999", value_out, 999);
    chk("err_sticky", err, 1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Backspace inside an entry; non-BCD digit flags err.
    dig(1); dig(2); step(1'b0, 0, 1'b1, 1'b0, 1'b0); dig(8);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0); idle();
    chk("vo_18", value_out, 18);
    dig(4'hC);
    chk("err_bcd", err, 1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Priority: enter beats digit, clear beats enter.
    dig(3); step(1'b1, 5, 1'b0, 1'b1, 1'b0); idle();
    chk("vo_3", value_out, 3);
    idle();
    dig(7); step(1'b0, 0, 1'b0, 1'b1, 1'b1); idle();
    chk("clr_enter_vv", value_valid, 0);
    chk("clr_enter_vo", value_out, 3);

    // enter / backspace while idle are silent no-ops.
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle();

    // Reset during COMMIT loses the commit.
    dig(5); dig(6); step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    resetn = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_vv", value_valid, 0);
    dig(2); dig(1); step(1'b0, 0, 1'b0, 1'b1, 1'b0); idle();
    chk("vo_21", value_out, 21);

    // Randomized strobes.
    for (int i = 0; i < 3000; i++) begin
      bit dv, bs, en, cl;
      int d;
      dv = ($urandom_range(0, 99) < 55);
      bs = ($urandom_range(0, 99) < 10);
      en = ($urandom_range(0, 99) < 12);
      cl = ($urandom_range(0, 99) < 3);
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      step(dv, d, bs, en, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dec_entry.md
# dec_entry

Decimal digit-entry block: accepts BCD digits one at a time from the input-handling logic, most significant first, and commits the assembled number as an unsigned 10-bit binary value. It is the inverse path of the score display, which goes from binary to decimal digits. Typical uses are entering a target score or a level number from switches and keys. It sits between the debounced key/switch front end and any consumer of a binary setting. It also exposes the in-progress entry so the existing decimal display can echo it.

## Interface
Parameters:
- MAX_DIGITS, 3, maximum digits per entry; fixed at 3 for 10-bit output.
- WIDTH, 10, width of binary outputs; must hold 10^MAX_DIGITS−1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- digit_in  in  4  BCD digit, sampled when digit_valid=1.
- digit_valid  in  1  single-cycle strobe: append digit_in.
- backspace  in  1  single-cycle strobe: drop last-entered digit.
- enter  in  1  single-cycle strobe: commit current entry.
- clear  in  1  single-cycle strobe: discard entry, clear err.
- entry_value  out  WIDTH  binary value of digits entered so far; registered.
- digit_count  out  2  number of digits held (0..MAX_DIGITS).
- value_out  out  WIDTH  last committed value; holds until next commit.
- value_valid  out  1  one-cycle pulse when value_out updates.
- err  out  1  sticky error flag.

## Operation
- Storage: three BCD registers d2,d1,d0, plus digit_count.
  - entry_value = d2·100 + d1·10 + d0, registered.
  - Empty positions hold 0.
- FSM states: IDLE (count=0), ENTRY (0<count<MAX_DIGITS), FULL (count=MAX_DIGITS), COMMIT (one cycle).
- Per-cycle priority when strobes coincide: clear > enter > backspace > digit_valid. Only the highest-priority strobe acts; the others are dropped.
- digit_valid:
  - In IDLE or ENTRY with digit_in ≤ 9: shift left (d2←d1, d1←d0, d0←digit_in) and increment count.
  - Leading zeros are accepted and counted.
- digit_valid with digit_in > 9, in any state: digit ignored, err←1.
- digit_valid in FULL: digit ignored, err←1, state stays FULL.
- digit_valid in COMMIT: ignored, no error.
- backspace: shift right (d0←d1, d1←d2, d2←0) and decrement count. In IDLE it is a no-op with no error.
- enter:
  - In ENTRY or FULL: go to COMMIT.
  - In IDLE: ignored; no pulse, no error.
- COMMIT, for exactly one cycle:
  - value_out←entry_value and value_valid=1.
  - Digits and count are cleared.
  - Next state is IDLE.
- clear, in any state: digits, count and err cleared, state→IDLE. value_out is kept.
- err: once set, stays set until clear or reset. enter does not clear it.
- Reset values: d2=d1=d0=0, count=0, entry_value=0, value_out=0, value_valid=0, err=0, state IDLE.

## Timing
- All outputs are registered; no combinational input→output path.
- Entry update latency:
  - A strobe sampled at edge N updates d*, count and err at edge N.
  - entry_value reflects the new digits at edge N+1 (one extra register stage).
- Commit latency:
  - enter sampled at edge N → state COMMIT after edge N.
  - Committed value is entry_value as of edge N+1, computed from digits present before enter.
  - value_out and value_valid are updated at edge N+1; value_valid is high for one cycle, then low.
- Strobes are assumed single-cycle. A strobe held high is treated as one action per cycle; there is no internal edge detect.
- resetn assertion mid-entry or mid-COMMIT forces reset values immediately. An in-flight commit is lost with no value_valid pulse.
- Maximum value is 999 (0x3E7). No overflow is possible within WIDTH.

## Structure
- Shared package dec_entry_pkg:
  - MAX_DIGITS and WIDTH constants.
  - BCD_MAX = 4'd9.
  - Digit weights 100/10/1.
  - State encoding IDLE/ENTRY/FULL/COMMIT.
- One sub-module: bcd3_to_bin, a combinational d2·100+d1·10+d0 using shift-add (×100 = ×64+×32+×4, ×10 = ×8+×2). Its output is registered in the parent.
- The FSM and digit shift register live in the top level.

## Test plan
- Reset, then digits 4, 2, 7 then enter → entry_value goes 4, 42, 427; one cycle later value_out=427 and value_valid pulses once; count=0, entry_value=0.
- Digits 9, 9, 9, then 5 → count stays 3, err=1, entry_value=999; enter → value_out=999; err still 1 until clear.
- Digits 1, 2, backspace, 8, enter → value_out=18; a digit_in=4'hC strobe sets err and leaves entry unchanged.
- Same-cycle enter+digit_valid(5) after digits 3 → value_out=3, digit 5 discarded. Same-cycle clear+enter → no value_valid, entry empty, err=0.
- enter in IDLE, and backspace in IDLE → no value_valid, no err, value_out unchanged from the previous commit.
- resetn pulled low the cycle after enter (entry 56) → no value_valid pulse, value_out=0, all outputs at reset values; entry works normally after release.
